// File: rtl/piso_pkg.sv
// Shared types and line-level constants for the parallel-in/serial-out framer.
// Build option: define PISO_PARITY_EN to add an even-parity bit to each frame.
package piso_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } piso_state_t;

  localparam logic PISO_START_BIT  = 1'b1;
  localparam logic PISO_STOP_BIT   = 1'b0;
  localparam logic PISO_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_shift_core.sv
// Load/shift register and bit counter for the framer; the FSM drives the enables.
// Build option: PISO_PARITY_EN adds a registered even-parity output of the loaded word.
module piso_shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  input  logic             cnt_clr,
  input  logic             cnt_en,
  output logic             bit0,
`ifdef PISO_PARITY_EN
  output logic             parity,
`endif
  output logic             last_bit
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: state is updated with <= so every register samples pre-edge values;
  // blocking = here would make the result depend on statement order.
  // NOTE: the data register is reset too, so a dropped frame leaves no stale
  // word behind; it is small enough that this costs nothing worth avoiding.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
    end else if (load_en) begin
      shift_q <= data_in;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  // Counter tracks which data bit is on the line; it stops at WIDTH-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef PISO_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (load_en) begin
      parity_q <= ^data_in;
    end
  end

  assign parity = parity_q;
`endif

  assign bit0     = shift_q[0];
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Framer: start bit 1, data LSB first, optional even parity, stop bit 0, idle 0.
// Build option: define PISO_PARITY_EN to insert the parity bit (frame WIDTH+3).
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  piso_state_t state_q, state_d;
  logic        serial_q, serial_d;
  logic        accept;
  logic        bit0, last_bit;
  logic        shift_en, cnt_clr, cnt_en;
`ifdef PISO_PARITY_EN
  logic        parity;
`endif

  assign load_ready = (state_q == ST_IDLE) || (state_q == ST_STOP);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_STOP);
  assign accept     = load_valid && load_ready && !reset;
  assign serial_out = serial_q;

  // NOTE: defaults first, so every path assigns state_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_START;
      ST_START:  state_d = ST_DATA;
      ST_DATA: begin
        if (last_bit) begin
`ifdef PISO_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = accept ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The line bit is registered from the next state, so it lines up with state_q.
  always_comb begin
    serial_d = PISO_IDLE_LEVEL;
    unique case (state_d)
      ST_START:  serial_d = PISO_START_BIT;
      ST_DATA:   serial_d = bit0;
`ifdef PISO_PARITY_EN
      ST_PARITY: serial_d = parity;
`endif
      ST_STOP:   serial_d = PISO_STOP_BIT;
      default:   serial_d = PISO_IDLE_LEVEL;
    endcase
  end

  // Consume bit 0 on every edge that puts a data bit on the line.
  assign shift_en = (state_d == ST_DATA);
  assign cnt_clr  = (state_q == ST_START);
  assign cnt_en   = (state_q == ST_DATA) && !last_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      serial_q <= PISO_IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      serial_q <= serial_d;
    end
  end

  piso_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_en  (accept),
    .data_in  (data_in),
    .shift_en (shift_en),
    .cnt_clr  (cnt_clr),
    .cnt_en   (cnt_en),
    .bit0     (bit0),
`ifdef PISO_PARITY_EN
    .parity   (parity),
`endif
    .last_bit (last_bit)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: a frame-level model queues the expected
// per-cycle line state; a negedge monitor pops and compares against the DUT.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 3;
`else
  localparam int FL = W + 2;
`endif

  typedef struct packed {
    logic so;
    logic busy;
    logic done;
    logic ready;
  } obs_t;

  localparam obs_t IDLE_OBS = 4'b0001;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready;
  logic         serial_out;
  logic         busy;
  logic         done;

  obs_t  cur = IDLE_OBS;
  obs_t  future[$];
  obs_t  exp_q[$];
  obs_t  mon_exp, mon_got;
  int    vectors = 0;
  int    miscompares = 0;
  int    cycle = 0;
  string phase = "init";

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input obs_t got, input obs_t req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: so/busy/done/ready got %b required %b",
               name, cycle, got, req);
    end
  endtask

  // Frame-level reference: an accepted word becomes a whole list of future cycles.
  function automatic void model_edge(input logic r, input logic v, input logic [W-1:0] d);
    if (r) begin
      future.delete();
    end else if (v && cur.ready) begin
      future.push_back(obs_t'(4'b1100));
      for (int i = 0; i < W; i++) future.push_back(obs_t'({d[i], 3'b100}));
`ifdef PISO_PARITY_EN
      future.push_back(obs_t'({^d, 3'b100}));
`endif
      future.push_back(obs_t'(4'b0111));
    end
    cur = (future.size() != 0) ? future.pop_front() : IDLE_OBS;
    exp_q.push_back(cur);
  endfunction

  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    reset      = r;
    load_valid = v;
    data_in    = d;
    @(posedge clk);
    model_edge(r, v, d);
    cycle++;
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_got = {serial_out, busy, done, load_ready};
        check(phase, mon_got, mon_exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    data_in = '0;

    phase = "reset";
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hFF);

    phase = "single_a5";
    step(1'b0, 1'b1, 8'hA5);
    repeat (FL + 3) step(1'b0, 1'b0, 8'h00);

    phase = "back_to_back";
    step(1'b0, 1'b1, 8'hA5);
    repeat (FL) step(1'b0, 1'b1, 8'h3C);
    repeat (FL + 3) step(1'b0, 1'b0, 8'h00);

    phase = "parity_07";
    step(1'b0, 1'b1, 8'h07);
    repeat (FL + 2) step(1'b0, 1'b0, 8'h00);

    phase = "reset_mid_frame";
    step(1'b0, 1'b1, 8'h5A);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'hC3);
    repeat (FL + 3) step(1'b0, 1'b0, 8'h00);

    phase = "midframe_noise";
    step(1'b0, 1'b1, 8'h96);
    repeat (FL - 2) step(1'b0, 1'($urandom_range(0, 1)), W'($urandom));
    repeat (FL + 3) step(1'b0, 1'b0, W'($urandom));

    phase = "random";
    repeat (3000) begin
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) != 0), W'($urandom));
    end
    repeat (FL + 3) step(1'b0, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
